// File: rtl/psg_pkg.sv
// Shared constants for the PSG bus-write front end: byte field layout,
// channel codes, register reset values and the write FSM state type.
package psg_pkg;

   localparam int LATCH_BIT = 7;
   localparam int CH_MSB    = 6;
   localparam int CH_LSB    = 5;
   localparam int TYPE_BIT  = 4;

   localparam logic [1:0] NOISE_CH        = 2'd3;
   localparam logic [3:0] ATTN_SILENT     = 4'hF;
   localparam logic [2:0] NOISE_RESET_VAL = 3'b000;

   typedef enum logic {
      IDLE,
      BUSY
   } wr_state_t;

endpackage

// File: rtl/psg_write_sync.sv
// Synchronizes the asynchronous we_n strobe and data byte into clk and
// emits a registered one-cycle write event with the byte aligned to it.
module psg_write_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       we_n,
   input  logic [7:0] data,
   output logic       wr_event,
   output logic [7:0] wr_data
);

   logic [SYNC_STAGES-1:0] we_sync;
   logic [7:0]             data_sync [SYNC_STAGES];
   logic                   we_prev;

   // Data takes the same path length as we_n so the byte lines up with the event.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         we_sync  <= '1;
         we_prev  <= 1'b1;
         wr_event <= 1'b0;
         wr_data  <= '1;
         for (int i = 0; i < SYNC_STAGES; i++) data_sync[i] <= '1;
      end else begin
         we_sync      <= {we_sync[SYNC_STAGES-2:0], we_n};
         data_sync[0] <= data;
         for (int i = 1; i < SYNC_STAGES; i++) data_sync[i] <= data_sync[i-1];
         we_prev      <= we_sync[SYNC_STAGES-1];
         wr_event     <= we_prev & ~we_sync[SYNC_STAGES-1];
         wr_data      <= data_sync[SYNC_STAGES-1];
      end
   end

endmodule

// File: rtl/psg_control_regs.sv
// SN76489 latch/data write decoder and channel control registers.
// Define PSG_READY_EN to add the post-write BUSY throttle on ready.
//
// state | meaning
// IDLE  | ready high, next write event is accepted
// BUSY  | ready low, counting READY_CYCLES; write events are dropped
module psg_control_regs
   import psg_pkg::*;
#(
   parameter int NUM_TONES                = 3,
   parameter int ATTENUATION_CONTROL_BITS = 4,
   parameter int FREQUENCY_COUNTER_BITS   = 10,
   parameter int NOISE_CONTROL_BITS       = 3,
   parameter int SYNC_STAGES              = 2,
   parameter int READY_CYCLES             = 32
) (
   input  logic                                              clk,
   input  logic                                              reset,
   input  logic [7:0]                                        data,
   input  logic                                              we_n,
   output logic                                              ready,
   output logic [ATTENUATION_CONTROL_BITS*(NUM_TONES+1)-1:0] attn,
   output logic [FREQUENCY_COUNTER_BITS*NUM_TONES-1:0]       tone_freq,
   output logic [NOISE_CONTROL_BITS-1:0]                     noise_ctrl,
   output logic                                              noise_reset
);

   localparam int AW = ATTENUATION_CONTROL_BITS;
   localparam int FW = FREQUENCY_COUNTER_BITS;

   logic       wr_event;
   logic [7:0] wr_data;
   logic       accept;

   logic [AW-1:0] attn_r [NUM_TONES+1];
   logic [FW-1:0] tone_r [NUM_TONES];
   logic [1:0]    latch_ch;
   logic          latch_type;

   logic       is_latch;
   logic [1:0] ch_sel;
   logic       type_sel;

   psg_write_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk      (clk),
      .reset    (reset),
      .we_n     (we_n),
      .data     (data),
      .wr_event (wr_event),
      .wr_data  (wr_data)
   );

   // A latch byte supplies its own target; a data byte reuses the stored one.
   assign is_latch = wr_data[LATCH_BIT];
   assign ch_sel   = is_latch ? wr_data[CH_MSB:CH_LSB] : latch_ch;
   assign type_sel = is_latch ? wr_data[TYPE_BIT] : latch_type;

`ifdef PSG_READY_EN
   localparam int CW = $clog2(READY_CYCLES + 1);

   wr_state_t state, state_nxt;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (accept)
            cnt <= CW'(READY_CYCLES - 1);
         else if (state == BUSY && cnt != '0)
            cnt <= cnt - 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      ready     = (state == IDLE);
      case (state)
         IDLE: if (wr_event) begin
            accept    = 1'b1;
            state_nxt = BUSY;
         end
         BUSY: if (cnt == '0) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end
`else
   assign ready  = 1'b1;
   assign accept = wr_event;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i <= NUM_TONES; i++) attn_r[i] <= AW'(ATTN_SILENT);
         for (int i = 0; i < NUM_TONES; i++) tone_r[i] <= '0;
         noise_ctrl  <= NOISE_CONTROL_BITS'(NOISE_RESET_VAL);
         latch_ch    <= 2'd0;
         latch_type  <= 1'b0;
         noise_reset <= 1'b0;
      end else begin
         noise_reset <= 1'b0;
         if (accept) begin
            if (is_latch) begin
               latch_ch   <= wr_data[CH_MSB:CH_LSB];
               latch_type <= wr_data[TYPE_BIT];
            end
            if (type_sel) begin
               attn_r[ch_sel] <= wr_data[AW-1:0];
            end else if (ch_sel == NOISE_CH) begin
               noise_ctrl  <= wr_data[NOISE_CONTROL_BITS-1:0];
               noise_reset <= 1'b1;
            end else if (is_latch) begin
               tone_r[ch_sel][3:0] <= wr_data[3:0];
            end else begin
               tone_r[ch_sel][FW-1:4] <= wr_data[FW-5:0];
            end
         end
      end
   end

   always_comb begin
      attn      = '0;
      tone_freq = '0;
      for (int i = 0; i <= NUM_TONES; i++) attn[i*AW +: AW] = attn_r[i];
      for (int i = 0; i < NUM_TONES; i++) tone_freq[i*FW +: FW] = tone_r[i];
   end

endmodule
